im_loader: RTL and testbench
============================

# im_loader

Boot-time instruction-memory loader: the write side of the 1024-word instruction memory that the fetch stage reads. It accepts a length-prefixed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses starting at 0. While a load is in progress it holds the CPU core in reset.

## Interface
Parameters:
- DEPTH, 1024, number of instruction words in IM.
- AW, 10, word-address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- im_we  output  1  IM write strobe, one cycle per word.
- im_waddr  output  AW  IM word address.
- im_wdata  output  32  IM write data.
- cpu_hold  output  1  keeps the CPU in reset while loading.
- done  output  1  level; load finished.
- err  output  1  level; load aborted because the length was greater than DEPTH.
- words_loaded  output  AW+1  count of words written in the current or last load.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE.
- A byte is accepted only on a cycle with byte_valid && byte_ready. byte_ready = 1 only in LEN_HI, LEN_LO and DATA.
- IDLE or DONE, with start = 1:
  - clear done, err, words_loaded, the byte counter and the write address;
  - set cpu_hold = 1;
  - go to LEN_HI.
- LEN_HI: the accepted byte becomes len[15:8]; go to LEN_LO.
- LEN_LO: the accepted byte becomes len[7:0]. Then:
  - len == 0: go to DONE (done = 1, no writes);
  - len > DEPTH: go to DONE with err = 1 and no writes;
  - otherwise go to DATA.
- DATA: accepted bytes shift into the word register MSB-first (first byte lands in [31:24]). A 2-bit byte counter wraps 3 -> 0; the 4th accepted byte moves the block to WRITE.
- WRITE (exactly one cycle):
  - im_we = 1, im_wdata = assembled word, im_waddr = current address;
  - next cycle: address and words_loaded increment;
  - if words_loaded + 1 == len, go to DONE, else back to DATA.
- DONE: done = 1, cpu_hold = 0. The block stays here until start or rst.
- start in LEN_HI, LEN_LO, DATA or WRITE is ignored.
- Length arithmetic is 16-bit unsigned. The comparison against DEPTH uses the full 16 bits, so no truncation is allowed.

## Timing
- Reset values: byte_ready 0, im_we 0, im_waddr 0, im_wdata 0, cpu_hold 0, done 0, err 0, words_loaded 0; state IDLE.
- rst mid-load aborts on the next edge:
  - im_we is low from that edge;
  - partially assembled bytes are discarded;
  - words already written to IM are left in IM.
- The state leaving IDLE/DONE on start registers on the same edge that samples start. byte_ready is high from the following cycle.
- Minimum of 5 cycles per word: 4 accept cycles plus 1 WRITE cycle with byte_ready = 0. Gaps on byte_valid stall without losing state.
- im_we, im_waddr and im_wdata are registered and stable for the whole WRITE cycle.
- cpu_hold falls on the same edge that done rises.
- err and done rise together on an oversize length.
- Bytes offered while in DONE or IDLE are not accepted.

## Test plan
- Basic load: start; stream 00 02, 20 11 00 01, 08 00 0C 05 -> im_we pulses twice; writes (0, 0x20110001) then (1, 0x08000C05); done = 1, words_loaded = 2, cpu_hold 1 -> 0.
- Back-pressure: same stream with byte_valid toggling 1-0-1-0 -> identical writes; byte_ready = 0 during each WRITE cycle; no duplicated or lost bytes.
- Boundaries:
  - len = 0 -> done within 1 cycle after LEN_LO, no im_we;
  - len = 1025 -> done = 1, err = 1, no im_we;
  - len = 1024 of incrementing words -> last write at address 1023, words_loaded = 1024.
- Reset mid-load: rst after 2 bytes of word 3 -> next cycle all outputs are at reset values; a new start/load rewrites from address 0 correctly.
- Restart: start while in DATA -> ignored, load completes. start while in DONE -> done and err clear, new load proceeds.

Source files
------------

// File: rtl/im_loader_if.sv
// Boot-loader bus: byte stream in, IM write port and load status out.
// master = stream source / status observer, slave = the loader itself.
interface im_loader_if #(
    parameter int AW = 10
);
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, im_we, im_waddr, im_wdata,
        input  cpu_hold, done, err, words_loaded
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, im_we, im_waddr, im_wdata,
        output cpu_hold, done, err, words_loaded
    );
endinterface

// File: rtl/im_loader.sv
// Length-prefixed byte stream -> big-endian 32-bit IM writes from address 0; holds the CPU while loading.
// Min 5 cycles/word (4 accepts + 1 WRITE); byte_ready drops in WRITE/IDLE/DONE, gaps on byte_valid stall losslessly.
module im_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic         clk,
    input  logic         rst,
    im_loader_if.slave   s_bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [15:0] LP_DEPTH = 16'(DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_len;
    logic [31:0]   r_word;
    logic [1:0]    r_bcnt;
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_cnt;
    logic          r_we;
    logic          r_hold;
    logic          r_done;
    logic          r_err;

    logic          w_ready;
    logic          w_accept;
    logic [15:0]   w_len_full;
    logic [AW:0]   w_cnt_inc;
    logic          w_last_word;
    logic          w_len_zero;
    logic          w_len_big;

    always_comb begin
        w_ready     = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA);
        w_accept    = s_bus.byte_valid && w_ready;
        // Full 16-bit length as it will be once the low byte lands
        w_len_full  = {r_len[15:8], s_bus.byte_in};
        w_len_zero  = (w_len_full == 16'd0);
        w_len_big   = (w_len_full > LP_DEPTH);
        w_cnt_inc   = r_cnt + 1'b1;
        w_last_word = (16'(w_cnt_inc) == r_len);

        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (s_bus.start) w_next = LEN_HI;
            LEN_HI:     if (w_accept) w_next = LEN_LO;
            LEN_LO:     if (w_accept) w_next = (w_len_zero || w_len_big) ? DONE : DATA;
            DATA:       if (w_accept && (r_bcnt == 2'd3)) w_next = WRITE;
            WRITE:      w_next = w_last_word ? DONE : DATA;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_word  <= '0;
            r_bcnt  <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= (w_next == WRITE);
            case (r_state)
                IDLE, DONE: begin
                    if (s_bus.start) begin
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                        r_cnt  <= '0;
                        r_bcnt <= '0;
                        r_addr <= '0;
                        r_word <= '0;
                        r_hold <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (w_accept) r_len[15:8] <= s_bus.byte_in;
                end
                LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= s_bus.byte_in;
                        if (w_len_zero || w_len_big) begin
                            r_done <= 1'b1;
                            r_err  <= w_len_big;
                            r_hold <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_word <= {r_word[23:0], s_bus.byte_in};
                        r_bcnt <= r_bcnt + 2'd1;
                    end
                end
                WRITE: begin
                    r_addr <= r_addr + 1'b1;
                    r_cnt  <= w_cnt_inc;
                    if (w_last_word) begin
                        r_done <= 1'b1;
                        r_hold <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // r_word is frozen during WRITE since no byte can be accepted there
    assign s_bus.byte_ready   = w_ready;
    assign s_bus.im_we        = r_we;
    assign s_bus.im_waddr     = r_addr;
    assign s_bus.im_wdata     = r_word;
    assign s_bus.cpu_hold     = r_hold;
    assign s_bus.done         = r_done;
    assign s_bus.err          = r_err;
    assign s_bus.words_loaded = r_cnt;
endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: scoreboard of expected IM writes, popped by a write monitor.
module tb_im_loader;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   wr_count = 0;
    logic [AW-1:0] last_addr = '0;
    logic [AW+31:0] exp_q[$];

    im_loader_if #(.AW(AW)) bus ();

    im_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every IM write must match the oldest expected write
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            logic [AW+31:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected got addr=%0d data=%h, none expected", bus.im_waddr, bus.im_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.im_waddr, bus.im_wdata} !== e) begin
                    failures++;
                    $display("FAIL wr_value got addr=%0d data=%h exp addr=%0d data=%h",
                             bus.im_waddr, bus.im_wdata, e[AW+31:32], e[31:0]);
                end
            end
            checks++;
            if (bus.byte_ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_in_write got=%b exp=0", bus.byte_ready);
            end
            wr_count++;
            last_addr = bus.im_waddr;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) @(negedge clk);
        @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout got ready=%b exp=1", bus.byte_ready);
        end
        @(posedge clk);
        #1 bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gap);
    endtask

    task automatic send_len(input logic [15:0] len, input int gap);
        send_byte(len[15:8], gap);
        send_byte(len[7:0], gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout got=%b exp=1", name, bus.done);
        end
    endtask

    task automatic check_status(input string name, input logic d, input logic e,
                                input logic h, input logic [AW:0] wl);
        checks++;
        if ({bus.done, bus.err, bus.cpu_hold, bus.words_loaded} !== {d, e, h, wl}) begin
            failures++;
            $display("FAIL %s got done=%b err=%b hold=%b wl=%0d exp done=%b err=%b hold=%b wl=%0d",
                     name, bus.done, bus.err, bus.cpu_hold, bus.words_loaded, d, e, h, wl);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({bus.byte_ready, bus.im_we, bus.im_waddr, bus.im_wdata} !== '0) begin
            failures++;
            $display("FAIL %s_bus got rdy=%b we=%b addr=%0d data=%h exp all 0",
                     name, bus.byte_ready, bus.im_we, bus.im_waddr, bus.im_wdata);
        end
        check_status({name, "_status"}, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready got=%b exp=0", bus.byte_ready);
        end
    endtask

    task automatic run_two_word(input string name, input int gap);
        exp_q.push_back({10'd0, 32'h2011_0001});
        exp_q.push_back({10'd1, 32'h0800_0C05});
        pulse_start();
        check_status({name, "_started"}, 1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (bus.byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_after_start got=%b exp=1", name, bus.byte_ready);
        end
        send_len(16'd2, gap);
        send_word(32'h2011_0001, gap);
        send_word(32'h0800_0C05, gap);
        wait_done(name);
        check_status({name, "_end"}, 1'b1, 1'b0, 1'b0, 11'd2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes got pending=%0d exp=0", name, exp_q.size());
        end
    endtask

    task automatic test_basic();
        run_two_word("basic", 0);
    endtask

    task automatic test_backpressure();
        run_two_word("bp", 1);
    endtask

    task automatic test_len_zero();
        int w0 = wr_count;
        pulse_start();
        send_len(16'd0, 0);
        check_status("len0", 1'b1, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_count != w0) begin
            failures++;
            $display("FAIL len0_writes got=%0d exp=%0d", wr_count, w0);
        end
    endtask

    task automatic test_oversize();
        int w0 = wr_count;
        pulse_start();
        send_len(16'd1025, 0);
        check_status("len1025", 1'b1, 1'b1, 1'b0, '0);
        repeat (6) @(negedge clk);
        checks++;
        if (wr_count != w0 || bus.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL len1025_idle got writes=%0d rdy=%b exp writes=%0d rdy=0",
                     wr_count - w0, bus.byte_ready, 0);
        end
    endtask

    task automatic test_full();
        logic [31:0] w;
        pulse_start();
        send_len(16'd1024, 0);
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'(i) ^ 32'hA500_0000;
            exp_q.push_back({AW'(i), w});
            send_word(w, 0);
        end
        wait_done("full");
        check_status("full_end", 1'b1, 1'b0, 1'b0, 11'd1024);
        checks++;
        if (last_addr !== 10'd1023 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL full_last got addr=%0d pending=%0d exp addr=1023 pending=0",
                     last_addr, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_len(16'd5, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({AW'(i), 32'h1000_0000 + 32'(i)});
            send_word(32'h1000_0000 + 32'(i), 0);
        end
        send_byte(8'hEE, 0);
        send_byte(8'hDD, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("mid_rst");
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_rst_pending got=%0d exp=0", exp_q.size());
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({10'd0, 32'hCAFE_F00D});
        pulse_start();
        send_len(16'd1, 0);
        send_word(32'hCAFE_F00D, 0);
        wait_done("reload");
        check_status("reload_end", 1'b1, 1'b0, 1'b0, 11'd1);
    endtask

    task automatic test_restart();
        exp_q.push_back({10'd0, 32'h1122_3344});
        exp_q.push_back({10'd1, 32'h5566_7788});
        pulse_start();
        send_len(16'd2, 0);
        send_word(32'h1122_3344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        pulse_start();
        check_status("start_in_data", 1'b0, 1'b0, 1'b1, 11'd1);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        wait_done("restart");
        check_status("restart_end", 1'b1, 1'b0, 1'b0, 11'd2);
        pulse_start();
        send_len(16'hFFFF, 0);
        check_status("err_set", 1'b1, 1'b1, 1'b0, '0);
        pulse_start();
        check_status("err_clear", 1'b0, 1'b0, 1'b1, '0);
        exp_q.push_back({10'd0, 32'h0BAD_BEEF});
        send_len(16'd1, 0);
        send_word(32'h0BAD_BEEF, 0);
        wait_done("after_err");
        check_status("after_err_end", 1'b1, 1'b0, 1'b0, 11'd1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_len_zero();
        test_oversize();
        test_full();
        test_reset_mid();
        test_restart();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_pending got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
